// File: rtl/ysyx_23060180_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the IFU and the LSU.
// One request in flight at a time; a WAIT-state timeout returns an error response.
module ysyx_23060180_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_in,
  input  logic            ifu_req,
  input  logic [AW-1:0]   ifu_addr,
  output logic            ifu_gnt,
  output logic            ifu_rvalid,
  output logic [DW-1:0]   ifu_rdata,
  output logic            ifu_err,
  input  logic            lsu_req,
  input  logic            lsu_we,
  input  logic [AW-1:0]   lsu_addr,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wmask,
  output logic            lsu_gnt,
  output logic            lsu_rvalid,
  output logic [DW-1:0]   lsu_rdata,
  output logic            lsu_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int MW = DW / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, ADDR, WAIT} state_t;

  state_t          state, state_nxt;
  logic            owner;      // 0 = IFU, 1 = LSU
  logic            last;
  logic            req_we;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic [MW-1:0]   req_wmask;
  logic [CW-1:0]   cnt;

  logic            sel_lsu;
  logic            take;
  logic            resp_vld;
  logic            resp_err;
  logic [DW-1:0]   resp_data;

  always_comb begin
    state_nxt = state;
    sel_lsu   = 1'b0;
    take      = 1'b0;
    mem_req   = 1'b0;
    resp_vld  = 1'b0;
    resp_err  = 1'b0;
    resp_data = '0;
    case (state)
      IDLE: begin
        if (ifu_req || lsu_req) begin
          // On a tie the requester that did not win last time goes first.
          sel_lsu   = lsu_req && (!ifu_req || !last);
          take      = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        mem_req = 1'b1;
        if (mem_gnt) state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          resp_vld  = 1'b1;
          resp_data = req_we ? '0 : mem_rdata;
          state_nxt = IDLE;
        end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
          resp_vld  = 1'b1;
          resp_err  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ifu_gnt    = take && !sel_lsu;
  assign lsu_gnt    = take && sel_lsu;
  assign ifu_rvalid = resp_vld && !owner;
  assign lsu_rvalid = resp_vld && owner;
  assign ifu_err    = resp_err && !owner;
  assign lsu_err    = resp_err && owner;
  assign ifu_rdata  = owner ? '0 : resp_data;
  assign lsu_rdata  = owner ? resp_data : '0;
  assign mem_we     = req_we;
  assign mem_addr   = req_addr;
  assign mem_wdata  = req_wdata;
  assign mem_wmask  = req_wmask;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wmask <= '0;
      cnt       <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        owner     <= sel_lsu;
        last      <= sel_lsu;
        req_we    <= sel_lsu ? lsu_we : 1'b0;
        req_addr  <= sel_lsu ? lsu_addr : ifu_addr;
        req_wdata <= sel_lsu ? lsu_wdata : '0;
        req_wmask <= sel_lsu ? lsu_wmask : '0;
      end
      if (state == ADDR && mem_gnt) cnt <= '0;
      else if (state == WAIT)       cnt <= cnt + CW'(1);
    end
  end

endmodule
